prim_fetch_sequencer: RTL and testbench

Sequences the ROM-to-RAM loader and the primitive vertex RAM for the line/triangle pipeline. After the first go request it triggers the one-shot ROM-to-RAM copy once and waits for it to complete. It then walks the RAM one primitive (9 words) at a time, latches each record and presents it to the rasterizer over a valid/ready handshake. It sits between the ROM2RAM loader and the line/triangle rasterizers.

---
 rtl/prim_fetch_sequencer_pkg.sv | 24 ++
 rtl/prim_fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_prim_fetch_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prim_fetch_sequencer_pkg.sv
// Shared types and defaults for the primitive fetch sequencer.
// Holds the state encoding, default record geometry and the packed record width.
package prim_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_REQ  = 3'd1,
        S_LOAD_WAIT = 3'd2,
        S_ADDR      = 3'd3,
        S_CAPTURE   = 3'd4,
        S_ISSUE     = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_WORDS_PER_PRIM = 9;
    localparam int DEF_PRIM_COUNT     = 2;
    localparam int PRIM_DATA_W        = 9 * DEF_DATA_WIDTH;

    function automatic int prim_data_width(input int data_width);
        return 9 * data_width;
    endfunction

endpackage

// File: rtl/prim_fetch_sequencer.sv
// Triggers the one-shot ROM-to-RAM copy, then walks the RAM one 9-word record
// at a time and presents each record to the rasterizer over valid/ready.
module prim_fetch_sequencer
    import prim_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int WORDS_PER_PRIM = DEF_WORDS_PER_PRIM,
    parameter int PRIM_COUNT     = DEF_PRIM_COUNT,
    localparam int IDX_W         = $clog2(PRIM_COUNT) + 1,
    localparam int REC_W         = prim_data_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  abort,
    output logic                  load_start,
    input  logic                  load_finish,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data1,
    input  logic [DATA_WIDTH-1:0] ram_read_data2,
    input  logic [DATA_WIDTH-1:0] ram_read_data3,
    input  logic [DATA_WIDTH-1:0] ram_read_data4,
    input  logic [DATA_WIDTH-1:0] ram_read_data5,
    input  logic [DATA_WIDTH-1:0] ram_read_data6,
    input  logic [DATA_WIDTH-1:0] ram_read_data7,
    input  logic [DATA_WIDTH-1:0] ram_read_data8,
    input  logic [DATA_WIDTH-1:0] ram_read_data9,
    output logic                  prim_valid,
    input  logic                  prim_ready,
    output logic [REC_W-1:0]      prim_data,
    output logic [IDX_W-1:0]      prim_index,
    output logic                  busy,
    output logic                  pass_done
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(WORDS_PER_PRIM);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(PRIM_COUNT - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base;
    logic                    loaded;
    logic                    load_requested;
    logic [ADDR_WIDTH-1:0]   next_base;

    assign next_base = base + STRIDE;

    // Outputs are registered, so each transition also loads the values
    // the destination state must present.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            base           <= '0;
            loaded         <= 1'b0;
            load_requested <= 1'b0;
            load_start     <= 1'b0;
            ram_read_addr  <= '0;
            prim_valid     <= 1'b0;
            prim_data      <= '0;
            prim_index     <= '0;
            busy           <= 1'b0;
            pass_done      <= 1'b0;
        end else if (abort && (state != S_IDLE)) begin
            // The loader has already seen its start pulse once LOAD_REQ is reached.
            if (state == S_LOAD_REQ) begin
                load_requested <= 1'b1;
            end
            state         <= S_IDLE;
            load_start    <= 1'b0;
            ram_read_addr <= '0;
            prim_valid    <= 1'b0;
            busy          <= 1'b0;
            pass_done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        base       <= '0;
                        prim_index <= '0;
                        busy       <= 1'b1;
                        if (loaded) begin
                            state         <= S_ADDR;
                            ram_read_addr <= '0;
                        end else if (load_requested) begin
                            state <= S_LOAD_WAIT;
                        end else begin
                            state      <= S_LOAD_REQ;
                            load_start <= 1'b1;
                        end
                    end
                end
                S_LOAD_REQ: begin
                    load_start     <= 1'b0;
                    load_requested <= 1'b1;
                    state          <= S_LOAD_WAIT;
                end
                S_LOAD_WAIT: begin
                    if (load_finish) begin
                        loaded        <= 1'b1;
                        ram_read_addr <= base;
                        state         <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= S_CAPTURE;
                end
                // Address has been stable for two cycles here, covering 0- or 1-cycle RAMs.
                S_CAPTURE: begin
                    prim_data  <= {ram_read_data9, ram_read_data8, ram_read_data7,
                                   ram_read_data6, ram_read_data5, ram_read_data4,
                                   ram_read_data3, ram_read_data2, ram_read_data1};
                    prim_valid <= 1'b1;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (prim_ready) begin
                        prim_valid <= 1'b0;
                        if (prim_index < LAST_IDX) begin
                            base          <= next_base;
                            prim_index    <= prim_index + IDX_W'(1);
                            ram_read_addr <= next_base;
                            state         <= S_ADDR;
                        end else begin
                            ram_read_addr <= '0;
                            pass_done     <= 1'b1;
                            state         <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    pass_done  <= 1'b0;
                    busy       <= 1'b0;
                    base       <= '0;
                    prim_index <= '0;
                    state      <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    load_start    <= 1'b0;
                    ram_read_addr <= '0;
                    prim_valid    <= 1'b0;
                    busy          <= 1'b0;
                    pass_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prim_fetch_sequencer.sv
// Directed and randomized bench for prim_fetch_sequencer with a loader/RAM model
// and a record-level reference (record k = ROM words 9k..9k+8 at address 9k).
module tb_prim_fetch_sequencer;
    import prim_fetch_sequencer_pkg::*;

    localparam int AW         = 8;
    localparam int DW         = 32;
    localparam int WPP        = 9;
    localparam int PC         = 2;
    localparam int IW         = $clog2(PC) + 1;
    localparam int PDW        = PRIM_DATA_W;
    localparam int LOAD_DELAY = 6;

    logic           clk;
    logic           reset;
    logic           go;
    logic           abort;
    logic           load_start;
    logic           load_finish;
    logic [AW-1:0]  ram_read_addr;
    logic           prim_valid;
    logic           prim_ready;
    logic [PDW-1:0] prim_data;
    logic [IW-1:0]  prim_index;
    logic           busy;
    logic           pass_done;

    logic [DW-1:0]  rom [256];
    logic [DW-1:0]  ram [256];
    logic [DW-1:0]  rd  [9];
    logic           ld_busy;
    int             ld_cnt;

    int             total = 0;
    int             bad   = 0;
    int             ls_cnt = 0;
    int             pd_cnt = 0;
    int             xq_idx [$];
    logic [PDW-1:0] xq_data [$];
    logic [AW-1:0]  xq_addr [$];

    prim_fetch_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_PRIM(WPP), .PRIM_COUNT(PC)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .load_start(load_start), .load_finish(load_finish),
        .ram_read_addr(ram_read_addr),
        .ram_read_data1(rd[0]), .ram_read_data2(rd[1]), .ram_read_data3(rd[2]),
        .ram_read_data4(rd[3]), .ram_read_data5(rd[4]), .ram_read_data6(rd[5]),
        .ram_read_data7(rd[6]), .ram_read_data8(rd[7]), .ram_read_data9(rd[8]),
        .prim_valid(prim_valid), .prim_ready(prim_ready), .prim_data(prim_data),
        .prim_index(prim_index), .busy(busy), .pass_done(pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-shot loader: copies ROM into RAM some cycles after its start pulse.
    always @(posedge clk) begin
        if (reset) begin
            load_finish <= 1'b0;
            ld_busy     <= 1'b0;
            ld_cnt      <= 0;
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (load_start && !ld_busy && !load_finish) begin
            ld_busy <= 1'b1;
            ld_cnt  <= LOAD_DELAY;
        end else if (ld_busy) begin
            if (ld_cnt == 0) begin
                ld_busy     <= 1'b0;
                load_finish <= 1'b1;
                for (int i = 0; i < 256; i++) ram[i] <= rom[i];
            end else begin
                ld_cnt <= ld_cnt - 1;
            end
        end
    end

    // RAM with one cycle of read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 9; k++) rd[k] <= ram[(int'(ram_read_addr) + k) % 256];
    end

    // Handshake monitor: a transfer is valid&ready without abort.
    always @(negedge clk) begin
        if (load_start) ls_cnt <= ls_cnt + 1;
        if (pass_done)  pd_cnt <= pd_cnt + 1;
        if (prim_valid && prim_ready && !abort && !reset) begin
            xq_idx.push_back(int'(prim_index));
            xq_data.push_back(prim_data);
            xq_addr.push_back(ram_read_addr);
        end
    end

    function automatic logic [PDW-1:0] exp_rec(input int k);
        logic [PDW-1:0] r;
        r = '0;
        for (int w = 0; w < WPP; w++) r[w*DW +: DW] = rom[k*WPP + w];
        return r;
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic go_v, input logic abort_v, input logic ready_v);
        go         = go_v;
        abort      = abort_v;
        prim_ready = ready_v;
    endtask

    task automatic checkOutput(input string tag, input logic [PDW-1:0] observed,
                               input logic [PDW-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pulse_go(input logic ready_v);
        applyStimulus(1'b1, 1'b0, ready_v);
        tick(1);
        applyStimulus(1'b0, 1'b0, ready_v);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!prim_valid && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput({tag, " valid"}, PDW'(prim_valid), PDW'(1));
    endtask

    task automatic wait_pass(input string tag, input int target, input int budget);
        int n = 0;
        while (pd_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput({tag, " pass_done"}, PDW'(pd_cnt), PDW'(target));
    endtask

    // Compares the transfer at position pos against record k of the reference.
    task automatic check_xfer(input string tag, input int pos, input int k);
        checkOutput({tag, " present"}, PDW'(xq_idx.size() > pos), PDW'(1));
        if (xq_idx.size() > pos) begin
            checkOutput({tag, " idx"},  PDW'(xq_idx[pos]),  PDW'(k));
            checkOutput({tag, " addr"}, PDW'(xq_addr[pos]), PDW'(k * WPP));
            checkOutput({tag, " data"}, xq_data[pos],       exp_rec(k));
        end
    endtask

    initial begin
        int ls_base;
        int pd_base;
        int xb;
        int n;

        fill_rom();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("rst load_start", PDW'(load_start),    '0);
        checkOutput("rst busy",       PDW'(busy),          '0);
        checkOutput("rst valid",      PDW'(prim_valid),    '0);
        checkOutput("rst index",      PDW'(prim_index),    '0);
        checkOutput("rst addr",       PDW'(ram_read_addr), '0);
        checkOutput("rst pass_done",  PDW'(pass_done),     '0);
        checkOutput("rst data",       prim_data,           '0);
        reset = 1'b0;
        tick(1);

        // First pass: load, then record 0 held while ready is low.
        $display("[TB] first pass with load");
        ls_base = ls_cnt;
        pulse_go(1'b0);
        checkOutput("t1 load_start", PDW'(load_start), PDW'(1));
        checkOutput("t1 busy",       PDW'(busy),       PDW'(1));
        wait_valid("t1", 50);
        checkOutput("t1 loads",  PDW'(ls_cnt - ls_base), PDW'(1));
        checkOutput("t1 busy2",  PDW'(busy),             PDW'(1));
        checkOutput("t1 addr",   PDW'(ram_read_addr),    PDW'(0));
        checkOutput("t1 index",  PDW'(prim_index),       PDW'(0));
        checkOutput("t1 data",   prim_data,              exp_rec(0));
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("t3 hold valid", PDW'(prim_valid), PDW'(1));
            checkOutput("t3 hold data",  prim_data,        exp_rec(0));
        end
        xb = xq_idx.size();
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t3 one xfer", PDW'(xq_idx.size() - xb), PDW'(1));
        check_xfer("t3 rec0", xb, 0);
        wait_valid("t2", 20);
        checkOutput("t2 addr",  PDW'(ram_read_addr), PDW'(WPP));
        checkOutput("t2 index", PDW'(prim_index),    PDW'(1));
        checkOutput("t2 data",  prim_data,           exp_rec(1));
        pd_base = pd_cnt;
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_pass("t2", pd_base + 1, 20);
        tick(6);
        checkOutput("t2 pd once", PDW'(pd_cnt - pd_base),     PDW'(1));
        checkOutput("t2 busy",    PDW'(busy),                 '0);
        checkOutput("t2 xfers",   PDW'(xq_idx.size() - xb),   PDW'(2));
        check_xfer("t2 rec1", xb + 1, 1);

        // Second pass: no reload, ADDR straight after IDLE.
        $display("[TB] second pass without load");
        ls_base = ls_cnt;
        pd_base = pd_cnt;
        xb = xq_idx.size();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        pulse_go(1'b0);
        checkOutput("t4 busy",       PDW'(busy),          PDW'(1));
        checkOutput("t4 load_start", PDW'(load_start),    '0);
        checkOutput("t4 addr",       PDW'(ram_read_addr), '0);
        tick(2);
        checkOutput("t4 valid at 3", PDW'(prim_valid),    PDW'(1));
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_pass("t4", pd_base + 1, 30);
        tick(2);
        checkOutput("t4 loads", PDW'(ls_cnt - ls_base),   '0);
        checkOutput("t4 xfers", PDW'(xq_idx.size() - xb), PDW'(2));
        check_xfer("t4 rec0", xb, 0);
        check_xfer("t4 rec1", xb + 1, 1);

        // Abort colliding with ready on record 0.
        $display("[TB] abort during record 0");
        applyStimulus(1'b0, 1'b0, 1'b0);
        pd_base = pd_cnt;
        xb = xq_idx.size();
        pulse_go(1'b0);
        wait_valid("t5", 20);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5 valid", PDW'(prim_valid),         '0);
        checkOutput("t5 busy",  PDW'(busy),               '0);
        tick(3);
        checkOutput("t5 no pd", PDW'(pd_cnt - pd_base),   '0);
        checkOutput("t5 no xf", PDW'(xq_idx.size() - xb), '0);
        pulse_go(1'b0);
        wait_valid("t5b", 20);
        checkOutput("t5 index", PDW'(prim_index), '0);
        checkOutput("t5 data",  prim_data,        exp_rec(0));

        // Randomized ready finishes this pass.
        n = 0;
        while (pd_cnt == pd_base && n < 300) begin
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            tick(1);
            n++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rnd pass_done", PDW'(pd_cnt - pd_base),   PDW'(1));
        checkOutput("rnd xfers",     PDW'(xq_idx.size() - xb), PDW'(2));
        check_xfer("rnd rec0", xb, 0);
        check_xfer("rnd rec1", xb + 1, 1);
        tick(2);

        // Reset in LOAD_WAIT re-arms the loader; new ROM contents must appear.
        $display("[TB] reset during load wait");
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        pulse_go(1'b0);
        tick(3);
        checkOutput("t6 in wait busy", PDW'(busy), PDW'(1));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("t6 rst busy",  PDW'(busy),       '0);
        checkOutput("t6 rst valid", PDW'(prim_valid), '0);
        tick(LOAD_DELAY + 4);
        fill_rom();
        ls_base = ls_cnt;
        pd_base = pd_cnt;
        xb = xq_idx.size();
        pulse_go(1'b0);
        wait_valid("t6", 50);
        checkOutput("t6 loads", PDW'(ls_cnt - ls_base), PDW'(1));
        pulse_go(1'b0);
        tick(3);
        checkOutput("t6 go ignored idx",   PDW'(prim_index), '0);
        checkOutput("t6 go ignored valid", PDW'(prim_valid), PDW'(1));
        checkOutput("t6 data",             prim_data,        exp_rec(0));
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_pass("t6", pd_base + 1, 30);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("t6 xfers", PDW'(xq_idx.size() - xb), PDW'(2));
        check_xfer("t6 rec0", xb, 0);
        check_xfer("t6 rec1", xb + 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
